param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. Supports arbitrary (non-power-of-2) DEPTH with all DEPTH entries usable. Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow flags and a selectable first-word-fall-through (FWFT) read mode. Sits between user-project producers and consumers, for example between the Wishbone decoder and the accelerator datapath.

Parameters:
DEPTH, 9, number of storage entries (>=2, any integer)
DATA_WIDTH, 8, data word width in bits
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = registered read (standard); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
rstfifo  in  1  synchronous clear, active-high
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read (pop) request
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: write request was rejected
underflow  out  1  sticky: read request was rejected

Behaviour:
- Widths: AW = max(1, $clog2(DEPTH)) for the pointers; CW = $clog2(DEPTH+1) for count.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Power-of-2 natural overflow must not be relied on.
- rst=0 (async): w_ptr=0, r_ptr=0, count=0, data_out=0, overflow=0, underflow=0. This gives empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- rstfifo=1 at a clock edge: same clear as rst. It has priority over w_en/r_en in the same cycle, and those requests are dropped without setting the sticky flags.
- rd_ok = r_en & !empty.
- wr_ok = w_en & (!full | rd_ok). At full with a simultaneous read, both operations are accepted.
- At empty with w_en & r_en: only the write is accepted, underflow is set, and count becomes 1.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. count never exceeds DEPTH or goes below 0.
- wr_ok: mem[w_ptr] <= data_in, w_ptr advances.
- rd_ok: r_ptr advances.
- FWFT=0:
  - data_out is a register, loaded with mem[r_ptr] on the rd_ok edge, so it is valid 1 cycle after the accepted read.
  - data_out holds its value when there is no rd_ok.
- FWFT=1:
  - data_out = mem[r_ptr] combinationally while !empty. It is 0 when empty, not X.
  - r_en acknowledges the current head word; the next word appears in the same cycle that r_ptr advances.
  - Write-to-visible latency is 1 cycle (written at edge N, visible after edge N).
- overflow: set on w_en & !wr_ok & !rstfifo.
- underflow: set on r_en & empty & !rstfifo.
- Both sticky flags are cleared only by rst or rstfifo.
- full, empty, almost_* are decoded combinationally from the registered count. There are no combinational paths from w_en/r_en to any flag.
- Elaboration: $error if AF_THRESH > DEPTH, AE_THRESH >= DEPTH, or DEPTH < 2.

Decomposition:
- No shared package is needed. Local parameters AW and CW are derived in-module.
- One natural sub-module, fifo_mem_2p: DEPTH x DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
- All pointer, count, flag and mode logic stays in param_sync_fifo.

Test Plan:
- Reset (DEPTH=9, DATA_WIDTH=8): drive rst=0 mid-traffic. Required immediately, without a clock edge: count=0, empty=1, full=0, data_out=0x00, overflow=0, underflow=0.
- Fill and overflow: write 0x01..0x09. Required: full=1 and count=9 after the 9th edge, almost_full=1 from count=8. An extra write of 0xAA gives overflow=1, count stays 9, and 0xAA is never read out.
- Drain and underflow (FWFT=0): 9 reads give data_out 0x01..0x09, each one cycle after its r_en edge, then empty=1. A 10th read gives underflow=1 and data_out holds 0x09.
- Wrap and non-power-of-2: write 5, read 5, then write 0x10..0x18. Required: w_ptr passes 8->0, reads return 0x10..0x18 in order, and count reaches 9 with no false full or empty.
- Simultaneous: at full, w_en=r_en=1 with 0x55 leaves count=9, pops the oldest word, and 0x55 is the last word out. At empty, w_en=r_en=1 with 0x66 gives count=1 and underflow=1.
- FWFT=1 and rstfifo:
  - Write 0x77: data_out=0x77 in the cycle after the write edge with no r_en. r_en then pops it and empty=1.
  - Assert rstfifo together with w_en 0x99: count=0, sticky flags cleared, 0x99 dropped.

Source files
------------

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH register array for param_sync_fifo.
// It has one synchronous write port and one asynchronous read port, and the contents are never reset.
module fifo_mem_2p #(
    parameter int DEPTH      = 9,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Both pointers wrap at DEPTH-1, so raddr always selects a real entry.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with arbitrary DEPTH, occupancy count, threshold flags,
// sticky overflow/underflow and a choice of registered or fall-through read.
module param_sync_fifo #(
    parameter int DEPTH      = 9,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0,
    localparam int AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rstfifo,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be below DEPTH");
    end

    logic [AW-1:0]         w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  rd_ok, wr_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // At full, a read in the same cycle frees a slot, so the write is also accepted.
    assign rd_ok = r_en & ~empty & ~rstfifo;
    assign wr_ok = w_en & (~full | (r_en & ~empty)) & ~rstfifo;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (rstfifo) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr_d = (w_ptr_q == AW'(DEPTH - 1)) ? '0 : w_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                r_ptr_d = (r_ptr_q == AW'(DEPTH - 1)) ? '0 : r_ptr_q + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
            if (w_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (r_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w_ptr_q),
        .wdata (data_in),
        .raddr (r_ptr_q),
        .rdata (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // The head word is shown directly; force zero while empty so stale or X contents never leak out.
        assign data_out = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

        always_comb begin
            data_out_d = data_out_q;
            if (rstfifo) begin
                data_out_d = '0;
            end else if (rd_ok) begin
                data_out_d = mem_rdata;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_out_q <= '0;
            end else begin
                data_out_q <= data_out_d;
            end
        end

        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised and directed bench for param_sync_fifo.
// It drives a registered-read instance and a fall-through instance from the same stimulus and checks both against a queue model.
module tb_param_sync_fifo;

    localparam int DEPTH = 9;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rstfifo = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [CW-1:0] cnt0, cnt1;

    int tests_run    = 0;
    int tests_failed = 0;
    int step_no      = 0;

    // Reference model: the queue holds the stored words, oldest first.
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_dout0 = '0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .rstfifo(rstfifo), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .rstfifo(rstfifo), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout0 = '0;
    endtask

    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
        int  n;
        logic rd, wr;
        if (clr) begin
            model_clear();
        end else begin
            n  = q.size();
            rd = r && (n > 0);
            wr = w && ((n < DEPTH) || rd);
            if (w && !wr) m_ovf = 1'b1;
            if (r && (n == 0)) m_unf = 1'b1;
            if (rd) m_dout0 = q.pop_front();
            if (wr) q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk({tag, ".count0"}, 32'(cnt0), 32'(n));
        chk({tag, ".count1"}, 32'(cnt1), 32'(n));
        chk({tag, ".empty"},  {30'd0, empty1, empty0}, {30'd0, n == 0, n == 0});
        chk({tag, ".full"},   {30'd0, full1, full0}, {30'd0, n == DEPTH, n == DEPTH});
        chk({tag, ".afull"},  {30'd0, af1, af0}, {30'd0, n >= AF, n >= AF});
        chk({tag, ".aempty"}, {30'd0, ae1, ae0}, {30'd0, n <= AE, n <= AE});
        chk({tag, ".ovf"},    {30'd0, ovf1, ovf0}, {30'd0, m_ovf, m_ovf});
        chk({tag, ".unf"},    {30'd0, unf1, unf0}, {30'd0, m_unf, m_unf});
        chk({tag, ".dout_reg"},  32'(dout0), 32'(m_dout0));
        chk({tag, ".dout_fwft"}, 32'(dout1), 32'(head));
    endtask

    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic clr);
        @(negedge clk);
        w_en    = w;
        data_in = d;
        r_en    = r;
        rstfifo = clr;
        @(posedge clk);
        model_edge(w, d, r, clr);
        #1;
        step_no++;
        check_all(tag);
        $display("[TB] %0d %s w=%0b d=%02h r=%0b clr=%0b cnt=%0d dout_reg=%02h dout_fwft=%02h",
                 step_no, tag, w, d, r, clr, cnt0, dout0, dout1);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; rstfifo = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_hold"});
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        model_clear();
        check_all("por");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 9; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step("pre_w", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("pre_r", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("wrap_w", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("sim_full", 1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
        step("sim_empty", 1'b1, 8'h66, 1'b1, 1'b0);
        step("pop66", 1'b0, 8'h00, 1'b1, 1'b0);

        step("fw_w", 1'b1, 8'h77, 1'b0, 1'b0);
        step("fw_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("fw_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        step("fw_w2", 1'b1, 8'h77, 1'b0, 1'b0);
        step("clr", 1'b1, 8'h99, 1'b1, 1'b1);
        step("post_clr", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step("traffic", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step("traffic_r", 1'b0, 8'h00, 1'b1, 1'b0);
        async_reset("arst");

        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 3);
            step("rand", w, 8'($urandom), r, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
